// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between eight requesters.
// One operation in flight; completion by alu_done or by timeout.
module alu_rr_arbiter #(
    parameter int N_REQ   = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             alu_done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             alu_start,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    localparam bit               TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic [N_REQ-1:0] oh;

    // First set request at or after ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_q + SEL_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = win;
                    err_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                    if (TO_EN && timer_q == T_MAX) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ptr_d   = sel_q + SEL_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Moore decode of registered state, winner and flag
    assign oh        = ONE << sel_q;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);
    assign alu_start = (state_q == START);
    assign grant     = busy ? oh : '0;
    assign ack       = (state_q == DONE) ? oh : '0;
    assign err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a winner/err scoreboard.
module tb_alu_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       alu_done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       alu_start;
    logic [7:0] ack;
    logic       err;
    logic       busy;

    typedef struct packed {
        logic [2:0] win;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_start = 0;
    logic [2:0] ptr_m;

    alu_rr_arbiter #(
        .N_REQ(8),
        .SEL_W(3),
        .TIMEOUT(TIMEOUT),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .alu_done(alu_done),
        .sel(sel),
        .grant(grant),
        .alu_start(alu_start),
        .ack(ack),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] r,
                                        input logic [2:0] p);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] j;
            j = p + 3'(i);
            if (r[j]) return j;
        end
        return p;
    endfunction

    // Entered at a negedge with the DUT idle; returns at the next idle negedge.
    // dly: WAIT cycle index carrying alu_done, negative for never.
    task automatic txn(input logic [7:0] r, input int dly, input bit stray,
                       input bit hold, input bit chain);
        exp_t e;
        exp_t got;
        int   k;
        int   exp_k;
        logic [7:0] oh;
        e.win = pick(r, ptr_m);
        e.err = (dly < 0 || dly > TIMEOUT - 1);
        exp_k = e.err ? TIMEOUT : dly + 1;
        ptr_m = e.win + 3'd1;
        sb.push_back(e);
        oh = 8'h01 << e.win;
        req = r;
        alu_done = stray;
        @(negedge clk);
        alu_done = stray;
        chk("alu_start", 32'(alu_start), 32'd1);
        chk("sel", 32'(sel), 32'(e.win));
        chk("grant", 32'(grant), 32'(oh));
        chk("busy", 32'(busy), 32'd1);
        if (chain) chk("spacing", 32'(cyc - last_start), 32'd4);
        last_start = cyc;
        if (!hold) req = '0;
        @(negedge clk);
        alu_done = 1'b0;
        chk("start_pulse", 32'(alu_start), 32'd0);
        k = 0;
        while (ack == '0 && k < 40) begin
            alu_done = (k == dly);
            @(negedge clk);
            alu_done = 1'b0;
            k++;
        end
        chk("wait_cycles", 32'(k), 32'(exp_k));
        got = sb.pop_front();
        chk("ack", 32'(ack), 32'(8'h01 << got.win));
        chk("err", 32'(err), 32'(got.err));
        chk("grant_done", 32'(grant), 32'(oh));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("sel_hold", 32'(sel), 32'(e.win));
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        alu_done = 1'b0;
        ptr_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_noreq", 32'(busy), 32'd0);

        txn(8'h08, 1, 1'b0, 1'b0, 1'b0);
        txn(8'h19, 0, 1'b0, 1'b0, 1'b0);
        txn(8'h80, 0, 1'b0, 1'b0, 1'b0);

        txn(8'hFF, 0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 7; n++) txn(8'hFF, 0, 1'b0, 1'b1, 1'b1);
        txn(8'hFF, 0, 1'b0, 1'b0, 1'b1);

        txn(8'h81, 0, 1'b0, 1'b0, 1'b0);
        txn(8'h81, 0, 1'b0, 1'b0, 1'b0);

        txn(8'h02, -1, 1'b0, 1'b0, 1'b0);
        txn(8'h04, 15, 1'b1, 1'b0, 1'b0);

        req = 8'h40;
        @(negedge clk);
        chk("pre_rst_start", 32'(alu_start), 32'd1);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_start", 32'(alu_start), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        ptr_m = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("no_ack_after_rst", 32'(ack), 32'd0);
        end

        txn(8'h21, 0, 1'b0, 1'b0, 1'b0);
        txn(8'h20, 2, 1'b0, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
